// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel front end (sobel_window_gen, sobel_calc).
//   PIX_W_DEF  : default pixel width
//   cnt_width  : width of a counter/address that indexes 0..depth-1
//   WIN_*      : positions inside the flattened 3x3 window, row-major,
//                top row oldest, left column oldest
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W_DEF = 32'sd8;

    // Window element indices, shared with sobel_calc (d0..d8)
    localparam int WIN_TL   = 32'sd0;
    localparam int WIN_TC   = 32'sd1;
    localparam int WIN_TR   = 32'sd2;
    localparam int WIN_ML   = 32'sd3;
    localparam int WIN_MC   = 32'sd4;
    localparam int WIN_MR   = 32'sd5;
    localparam int WIN_BL   = 32'sd6;
    localparam int WIN_BC   = 32'sd7;
    localparam int WIN_BR   = 32'sd8;
    localparam int WIN_SIZE = 32'sd9;

    // Bits needed to hold 0..depth-1; never less than one bit
    function automatic int cnt_width(input int depth);
        int w;
        if (depth > 32'sd1) begin
            w = $clog2(depth);
        end else begin
            w = 32'sd1;
        end
        return w;
    endfunction

endpackage : sobel_pkg

// File: rtl/sobel_window_gen_if.sv
// -----------------------------------------------------------------------------
// sobel_window_gen_if
// Pixel-in / window-out bundle of sobel_window_gen.
//   pixel_i, valid_i, sof_i : raster pixel stream (driven by the master)
//   d0_o..d8_o, done_o      : 3x3 window and its strobe (driven by the slave)
// master = pixel source / window consumer, slave = sobel_window_gen.
// -----------------------------------------------------------------------------
interface sobel_window_gen_if #(
    parameter int PIX_W = 32'sd8
);

    logic [PIX_W-1:0] pixel_i;
    logic             valid_i;
    logic             sof_i;

    logic [PIX_W-1:0] d0_o;
    logic [PIX_W-1:0] d1_o;
    logic [PIX_W-1:0] d2_o;
    logic [PIX_W-1:0] d3_o;
    logic [PIX_W-1:0] d4_o;
    logic [PIX_W-1:0] d5_o;
    logic [PIX_W-1:0] d6_o;
    logic [PIX_W-1:0] d7_o;
    logic [PIX_W-1:0] d8_o;
    logic             done_o;

    modport master (
        output pixel_i, valid_i, sof_i,
        input  d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o
    );

    modport slave (
        input  pixel_i, valid_i, sof_i,
        output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o
    );

endinterface : sobel_window_gen_if

// File: rtl/sobel_line_buf.sv
// -----------------------------------------------------------------------------
// sobel_line_buf
// One image row of pixel storage, single address port, read-before-write.
//   clk   : clock, rising edge
//   we    : write enable (one pixel beat)
//   addr  : column index 0..DEPTH-1, used for both read and write
//   wdata : pixel to store at addr on the enabled edge
//   rdata : current content at addr; during a write cycle this is the old
//           word, which the caller captures on the same edge as the write
// Contents are not reset; the consumer only looks at rdata once the
// addressed word has been written in the current frame.
// -----------------------------------------------------------------------------
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int DEPTH = 32'sd640,
    parameter int AW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem_r [DEPTH];

    // Old word at addr, visible before the edge that overwrites it
    assign rdata = mem_r[addr];

    // Store the new pixel on an enabled beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule : sobel_line_buf

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Builds 3x3 neighbourhoods from a raster-scan grayscale stream for sobel_calc.
//   clk    : clock, rising edge
//   rst    : asynchronous, active-high reset
//   win_if : slave side of sobel_window_gen_if
//            pixel_i/valid_i/sof_i in, d0_o..d8_o/done_o out
// Two line buffers hold rows r-1 and r-2. Every valid beat shifts a new
// column (r-2, r-1, r at column c) into the window. A beat at (r, c) with
// r >= 2 and c >= 2 completes the window centred on (r-1, c-1), which is
// registered onto d*_o with a one-cycle done_o pulse. Outside those pulses
// d*_o keep their last window, so uninitialised RAM never reaches them.
// -----------------------------------------------------------------------------
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int IMG_WIDTH  = 32'sd640,
    parameter int IMG_HEIGHT = 32'sd480
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_gen_if.slave win_if
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 32'sd1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 32'sd1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(32'sd2);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(32'sd2);
    localparam logic [CW-1:0] COL_ONE       = CW'(1'b1);
    localparam logic [RW-1:0] ROW_ONE       = RW'(1'b1);

    // Position bookkeeping
    logic [CW-1:0]    col_r;
    logic [RW-1:0]    row_r;
    logic [CW-1:0]    col_eff_s;
    logic [RW-1:0]    row_eff_s;
    logic [CW-1:0]    col_nxt_s;
    logic [RW-1:0]    row_nxt_s;
    logic             beat_s;
    logic             win_ok_s;

    // Line buffer read data (rows r-2 and r-1 at the beat column)
    logic [PIX_W-1:0] lb0_rd_s;
    logic [PIX_W-1:0] lb1_rd_s;

    // Window shift registers and registered outputs
    logic [PIX_W-1:0] win_r     [WIN_SIZE];
    logic [PIX_W-1:0] win_nxt_s [WIN_SIZE];
    logic [PIX_W-1:0] d_r       [WIN_SIZE];
    logic             done_r;

    // Effective beat position: a start-of-frame beat is (0,0) whatever the counters say
    always_comb begin
        beat_s = win_if.valid_i;
        if (win_if.valid_i && win_if.sof_i) begin
            col_eff_s = '0;
            row_eff_s = '0;
        end else begin
            col_eff_s = col_r;
            row_eff_s = row_r;
        end
        win_ok_s = beat_s && (col_eff_s >= COL_FIRST_WIN) && (row_eff_s >= ROW_FIRST_WIN);
    end

    // Counter successor of the current beat: col wraps into row, row wraps at frame end
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (beat_s) begin
            if (col_eff_s == COL_LAST) begin
                col_nxt_s = '0;
                if (row_eff_s == ROW_LAST) begin
                    row_nxt_s = '0;
                end else begin
                    row_nxt_s = row_eff_s + ROW_ONE;
                end
            end else begin
                col_nxt_s = col_eff_s + COL_ONE;
                row_nxt_s = row_eff_s;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Row r-1 store: takes the incoming pixel, hands its old word down to lb0
    sobel_line_buf #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (beat_s),
        .addr  (col_eff_s),
        .wdata (win_if.pixel_i),
        .rdata (lb1_rd_s)
    );

    // Row r-2 store: fed by the word lb1 is about to lose
    sobel_line_buf #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (beat_s),
        .addr  (col_eff_s),
        .wdata (lb1_rd_s),
        .rdata (lb0_rd_s)
    );

    // Window after this beat: shift columns left, new right column from the line buffers and pixel_i
    always_comb begin
        win_nxt_s         = win_r;
        win_nxt_s[WIN_TL] = win_r[WIN_TC];
        win_nxt_s[WIN_TC] = win_r[WIN_TR];
        win_nxt_s[WIN_TR] = lb0_rd_s;
        win_nxt_s[WIN_ML] = win_r[WIN_MC];
        win_nxt_s[WIN_MC] = win_r[WIN_MR];
        win_nxt_s[WIN_MR] = lb1_rd_s;
        win_nxt_s[WIN_BL] = win_r[WIN_BC];
        win_nxt_s[WIN_BC] = win_r[WIN_BR];
        win_nxt_s[WIN_BR] = win_if.pixel_i;
    end

    // Column/row counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Window shift registers advance on every valid beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r <= '{default: '0};
        end else if (beat_s) begin
            win_r <= win_nxt_s;
        end else begin
            win_r <= win_r;
        end
    end

    // Output window and strobe: loaded only for windows fully inside the image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r    <= '{default: '0};
            done_r <= 1'b0;
        end else begin
            done_r <= win_ok_s;
            if (win_ok_s) begin
                d_r <= win_nxt_s;
            end else begin
                d_r <= d_r;
            end
        end
    end

    assign win_if.d0_o   = d_r[WIN_TL];
    assign win_if.d1_o   = d_r[WIN_TC];
    assign win_if.d2_o   = d_r[WIN_TR];
    assign win_if.d3_o   = d_r[WIN_ML];
    assign win_if.d4_o   = d_r[WIN_MC];
    assign win_if.d5_o   = d_r[WIN_MR];
    assign win_if.d6_o   = d_r[WIN_BL];
    assign win_if.d7_o   = d_r[WIN_BC];
    assign win_if.d8_o   = d_r[WIN_BR];
    assign win_if.done_o = done_r;

endmodule : sobel_window_gen
